// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing constants for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int VEC_W = 3;
    localparam int TBL_W = 8;
    localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter that sets how long each vector is held.
module settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Load takes priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_value;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all eight input vectors of a 3-input block, holding each for
// settle+1 cycles, and captures the block's response into table_out.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle,
    input  logic [TBL_W-1:0]    expected,
    input  logic                out_sample,
    output logic                in1,
    output logic                in2,
    output logic                in3,
    output logic                busy,
    output logic                done,
    output logic [TBL_W-1:0]    table_out,
    output logic                match
);

    state_t              state_r;
    logic [VEC_W-1:0]    vec_r;
    logic [VEC_W-1:0]    drive_r;
    logic [SETTLE_W-1:0] settle_r;
    logic [TBL_W-1:0]    expected_r;
    logic [TBL_W-1:0]    table_r;
    logic                match_r;
    logic                busy_r;
    logic                done_r;

    logic                load_s;
    logic [SETTLE_W-1:0] load_value_s;
    logic                dec_s;
    logic                cnt_zero_s;

    settle_counter #(.W(SETTLE_W)) u_settle_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .load_value (load_value_s),
        .dec        (dec_s),
        .zero       (cnt_zero_s)
    );

    // Counter control: load on accepted start or vector advance, clear on abort.
    always_comb begin
        load_s       = 1'b0;
        load_value_s = {SETTLE_W{1'b0}};
        dec_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    load_s       = 1'b1;
                    load_value_s = settle;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    load_s = 1'b1;
                end else if (cnt_zero_s) begin
                    load_s       = 1'b1;
                    load_value_s = (vec_r == VEC_LAST) ? {SETTLE_W{1'b0}} : settle_r;
                end else begin
                    dec_s = 1'b1;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Sweep sequencing, capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            vec_r      <= {VEC_W{1'b0}};
            drive_r    <= {VEC_W{1'b0}};
            settle_r   <= {SETTLE_W{1'b0}};
            expected_r <= {TBL_W{1'b0}};
            table_r    <= {TBL_W{1'b0}};
            match_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        settle_r   <= settle;
                        expected_r <= expected;
                        table_r    <= {TBL_W{1'b0}};
                        match_r    <= 1'b0;
                        vec_r      <= {VEC_W{1'b0}};
                        drive_r    <= {VEC_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= ST_APPLY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        // Partial table is kept; the sweep never reached a verdict.
                        state_r <= ST_IDLE;
                        vec_r   <= {VEC_W{1'b0}};
                        drive_r <= {VEC_W{1'b0}};
                        busy_r  <= 1'b0;
                        match_r <= 1'b0;
                    end else if (cnt_zero_s) begin
                        table_r[vec_r] <= out_sample;
                        if (vec_r == VEC_LAST) begin
                            match_r <= ({out_sample, table_r[TBL_W-2:0]} == expected_r);
                            state_r <= ST_DONE;
                            vec_r   <= {VEC_W{1'b0}};
                            drive_r <= {VEC_W{1'b0}};
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            vec_r   <= vec_r + 3'd1;
                            drive_r <= vec_r + 3'd1;
                        end
                    end else begin
                        state_r <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    drive_r <= {VEC_W{1'b0}};
                end
            endcase
        end
    end

    assign {in1, in2, in3} = drive_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign table_out       = table_r;
    assign match           = match_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and random sweeps.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] settle;
    logic [7:0] expected;
    logic       out_sample;
    logic       in1, in2, in3;
    logic       busy, done, match;
    logic [7:0] table_out;

    // Model of the block under sweep: truth table f_tbl, optionally one cycle late.
    logic [7:0] f_tbl;
    logic       dly_mode;
    logic       f_dly;

    int n_checks = 0;
    int n_fail   = 0;

    truth_table_sweeper #(.SETTLE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .settle     (settle),
        .expected   (expected),
        .out_sample (out_sample),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .busy       (busy),
        .done       (done),
        .table_out  (table_out),
        .match      (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) f_dly <= f_tbl[{in1, in2, in3}];
    assign out_sample = dly_mode ? f_dly : f_tbl[{in1, in2, in3}];

    typedef struct {
        int         s;
        logic [7:0] f;
        logic [7:0] e;
        logic       dly;
        logic [7:0] t;
        logic       m;
    } vec_rec_t;

    vec_rec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected capture: a late block with no settle time is seen one vector behind.
    function automatic logic [7:0] ref_table(input logic [7:0] f, input logic d, input int s);
        logic [7:0] r;
        if (!d || s > 0) begin
            r = f;
        end else begin
            r[0] = f[0];
            for (int k = 1; k < 8; k++) r[k] = f[k-1];
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge one cycle after the DONE cycle.
    task automatic sweep(input int s, input logic [7:0] e, input logic [7:0] req_t,
                         input logic req_m, input int restart_j);
        int n;
        n = 8 * (s + 1);
        settle   = 4'(s);
        expected = e;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        settle   = 4'($urandom_range(0, 15));
        expected = 8'($urandom);
        for (int j = 0; j <= n; j++) begin
            if (j < n) begin
                check("busy", 32'(busy), 32'd1);
                check("done_early", 32'(done), 32'd0);
                check("vec", 32'({in1, in2, in3}), 32'(j / (s + 1)));
                if (j == 0) begin
                    check("match_clr", 32'(match), 32'd0);
                    check("table_clr", 32'(table_out), 32'd0);
                end
            end else begin
                check("done", 32'(done), 32'd1);
                check("busy_done", 32'(busy), 32'd0);
                check("vec_done", 32'({in1, in2, in3}), 32'd0);
                check("table", 32'(table_out), 32'(req_t));
                check("match", 32'(match), 32'(req_m));
            end
            start = (j == restart_j);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] rt;
        int         s;
        logic [7:0] e;

        tbl[0] = '{0,  8'h25, 8'h25, 1'b0, 8'h25, 1'b1};
        tbl[1] = '{3,  8'h25, 8'hA4, 1'b0, 8'h25, 1'b0};
        tbl[2] = '{1,  8'h25, 8'h25, 1'b1, 8'h25, 1'b1};
        tbl[3] = '{0,  8'h25, 8'h25, 1'b1, 8'h4B, 1'b0};
        tbl[4] = '{0,  8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1};
        tbl[5] = '{15, 8'h96, 8'h96, 1'b0, 8'h96, 1'b1};

        rst = 1'b1; start = 1'b1; abort = 1'b0; settle = 4'd2; expected = 8'hFF;
        f_tbl = 8'h25; dly_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_vec", 32'({in1, in2, in3}), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        rst = 1'b0;
        start = 1'b0;

        // Start accepted on the first edge after reset release.
        sweep(0, 8'h25, 8'h25, 1'b1, -1);

        for (int i = 0; i < 6; i++) begin
            f_tbl    = tbl[i].f;
            dly_mode = tbl[i].dly;
            @(negedge clk);
            sweep(tbl[i].s, tbl[i].e, tbl[i].t, tbl[i].m, -1);
            check("hold_table", 32'(table_out), 32'(tbl[i].t));
            check("hold_match", 32'(match), 32'(tbl[i].m));
        end

        // Start re-pulsed mid-sweep, then in the DONE cycle, then right after.
        f_tbl = 8'h25; dly_mode = 1'b0;
        @(negedge clk);
        sweep(1, 8'h25, 8'h25, 1'b1, 5);
        sweep(0, 8'h25, 8'h25, 1'b1, 8);
        sweep(2, 8'h24, 8'h25, 1'b0, -1);

        // Abort while vec=4.
        @(negedge clk);
        settle = 4'd0; expected = 8'h25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_vec4", 32'({in1, in2, in3}), 32'd4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_vec", 32'({in1, in2, in3}), 32'd0);
        check("abort_table", 32'(table_out), 32'h05);
        check("abort_match", 32'(match), 32'd0);
        for (int k = 0; k < 10; k++) begin
            check("abort_nodone", 32'(done), 32'd0);
            @(negedge clk);
        end

        // Abort and start together in IDLE: no sweep.
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_table", 32'(table_out), 32'h05);

        // Reset while vec=6, then a fresh full sweep.
        settle = 4'd0; expected = 8'h25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_vec6", 32'({in1, in2, in3}), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_vec", 32'({in1, in2, in3}), 32'd0);
        check("mrst_table", 32'(table_out), 32'd0);
        check("mrst_match", 32'(match), 32'd0);
        sweep(0, 8'h25, 8'h25, 1'b1, -1);

        // Random sweeps against the reference model.
        for (int it = 0; it < 20; it++) begin
            f_tbl    = 8'($urandom);
            dly_mode = 1'($urandom_range(0, 1));
            s        = int'($urandom_range(0, 3));
            rt       = ref_table(f_tbl, dly_mode, s);
            e        = ($urandom_range(0, 1) == 0) ? rt : 8'($urandom);
            @(negedge clk);
            sweep(s, e, rt, (rt == e), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8 * (s + 1))) : -1);
            repeat (2) @(negedge clk);
            check("rand_hold_table", 32'(table_out), 32'(rt));
            check("rand_hold_match", 32'(match), 32'(rt == e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
